// File: rtl/dht_reader.sv
// dht_reader: DHT11/DHT22 single-wire reader with start pulse, frame decode, checksum and timeouts
// Ports: clk/reset (sync, active-high); start pulse or auto_en polling; dht_data open-drain line;
//        busy, valid pulse, humidity/temperature in 0.1 units, raw_frame, checksum_err, timeout_err.
module dht_reader #(
   parameter int CLK_FREQ_HZ   = 1_000_000,
   parameter int SENSOR_TYPE   = 0,
   parameter int START_LOW_US  = 18000,
   parameter int POLL_MS       = 3000,
   parameter int TIMEOUT_US    = 200,
   parameter int BIT_THRESH_US = 40
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        auto_en,
   inout  wire         dht_data,
   output logic        busy,
   output logic        valid,
   output logic [15:0] humidity,
   output logic [15:0] temperature,
   output logic [39:0] raw_frame,
   output logic        checksum_err,
   output logic        timeout_err
);
   localparam int DIV = CLK_FREQ_HZ / 1_000_000;
   localparam bit DHT22 = SENSOR_TYPE != 0;
   typedef enum logic [2:0] {IDLE, START_LOW, RESP_WAIT, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, CHECK} state_t;
   state_t state;
   logic [15:0] pre;
   logic [9:0] ms_pre;
   logic [15:0] poll_cnt;
   logic [19:0] cnt;
   logic [5:0] bcnt;
   logic [39:0] sr;
   logic [2:0] sync;
   logic pedge, nedge, drive_low, tick, ev, expired, poll_due;
   logic [7:0] b0, b1, b2, b3, b4, sum;
   logic [15:0] hum_d, mag, temp_d;
   logic neg;
   assign dht_data = drive_low ? 1'b0 : 1'bz;
   assign tick = pre == 16'(DIV - 1);
   assign {b0, b1, b2, b3, b4} = sr;
   assign sum = b0 + b1 + b2 + b3;
   assign poll_due = auto_en && poll_cnt >= 16'(POLL_MS);
   always_comb begin
      hum_d = DHT22 ? {b0, b1} : 16'(b0) * 16'd10 + 16'(b1 > 8'd9 ? 8'd9 : b1);
      mag = DHT22 ? {1'b0, b2[6:0], b3} : 16'(b2) * 16'd10 + 16'(b3[6:0] > 7'd9 ? 7'd9 : b3[6:0]);
      neg = DHT22 ? b2[7] : b3[7];
      temp_d = neg ? -mag : mag;
      // RESP_LOW and BIT_LOW wait for the line to rise, every other wait phase for it to fall
      ev = (state == RESP_LOW || state == BIT_LOW) ? pedge : nedge;
      expired = tick && cnt >= 20'(TIMEOUT_US - 1) && state >= RESP_WAIT && state <= BIT_HIGH;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         pre <= '0;
         ms_pre <= '0;
         poll_cnt <= '0;
         cnt <= '0;
         bcnt <= '0;
         sr <= '0;
         sync <= '1;
         pedge <= 1'b0;
         nedge <= 1'b0;
         drive_low <= 1'b0;
         busy <= 1'b0;
         valid <= 1'b0;
         humidity <= '0;
         temperature <= '0;
         raw_frame <= '0;
         checksum_err <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         pre <= tick ? '0 : pre + 16'd1;
         sync <= {sync[1:0], dht_data};
         pedge <= sync[1] & ~sync[2];
         nedge <= ~sync[1] & sync[2];
         if (tick) begin
            ms_pre <= ms_pre == 10'd999 ? '0 : ms_pre + 10'd1;
            if (ms_pre == 10'd999 && poll_cnt < 16'(POLL_MS)) poll_cnt <= poll_cnt + 16'd1;
         end
         cnt <= tick ? cnt + 20'd1 : cnt;
         valid <= 1'b0;
         if (expired && !ev) begin
            timeout_err <= 1'b1;
            busy <= 1'b0;
            state <= IDLE;
         end else
            case (state)
               IDLE:
                  if (start || poll_due) begin
                     state <= START_LOW;
                     drive_low <= 1'b1;
                     busy <= 1'b1;
                     cnt <= '0;
                     bcnt <= '0;
                     checksum_err <= 1'b0;
                     timeout_err <= 1'b0;
                     ms_pre <= '0;
                     poll_cnt <= '0;
                  end
               START_LOW:
                  if (tick && cnt == 20'(START_LOW_US - 1)) begin
                     drive_low <= 1'b0;
                     state <= RESP_WAIT;
                     cnt <= '0;
                  end
               RESP_WAIT, RESP_LOW, RESP_HIGH, BIT_LOW:
                  if (ev) begin
                     state <= state_t'(state + 3'd1);
                     cnt <= '0;
                  end
               BIT_HIGH:
                  if (ev) begin
                     sr <= {sr[38:0], cnt > 20'(BIT_THRESH_US)};
                     bcnt <= bcnt + 6'd1;
                     state <= bcnt == 6'd39 ? CHECK : BIT_LOW;
                     cnt <= '0;
                  end
               CHECK: begin
                  raw_frame <= sr;
                  busy <= 1'b0;
                  state <= IDLE;
                  if (sum == b4) begin
                     valid <= 1'b1;
                     humidity <= hum_d;
                     temperature <= temp_d;
                  end else
                     checksum_err <= 1'b1;
               end
            endcase
      end
   end
endmodule

// File: tb/tb_dht_reader.sv
// tb_dht_reader: sensor-model bench for dht_reader (DHT22, slow DHT11, fast DHT11 instances)
`timescale 1ns/1ps
module tb_dht_reader;
   logic clk = 1'b0, reset = 1'b1;
   logic [2:0] start = '0, auto_en = '0, sl = '0;
   wire l0, l1, l2;
   wire [2:0] lv;
   wire [2:0] busy, valid, cs_err, to_err;
   wire [2:0][15:0] hum, tmp;
   wire [2:0][39:0] raw;
   assign l0 = sl[0] ? 1'b0 : 1'bz;
   assign l1 = sl[1] ? 1'b0 : 1'bz;
   assign l2 = sl[2] ? 1'b0 : 1'bz;
   pullup (l0);
   pullup (l1);
   pullup (l2);
   assign lv = {l2, l1, l0};
   always #500 clk = ~clk;

   dht_reader #(.CLK_FREQ_HZ(1_000_000), .SENSOR_TYPE(1), .START_LOW_US(1100), .POLL_MS(5),
                .TIMEOUT_US(200), .BIT_THRESH_US(40)) u22 (
      .clk(clk), .reset(reset), .start(start[0]), .auto_en(auto_en[0]), .dht_data(l0),
      .busy(busy[0]), .valid(valid[0]), .humidity(hum[0]), .temperature(tmp[0]),
      .raw_frame(raw[0]), .checksum_err(cs_err[0]), .timeout_err(to_err[0]));
   dht_reader #(.CLK_FREQ_HZ(1_000_000), .SENSOR_TYPE(0), .START_LOW_US(18000), .POLL_MS(3000),
                .TIMEOUT_US(200), .BIT_THRESH_US(40)) u11 (
      .clk(clk), .reset(reset), .start(start[1]), .auto_en(auto_en[1]), .dht_data(l1),
      .busy(busy[1]), .valid(valid[1]), .humidity(hum[1]), .temperature(tmp[1]),
      .raw_frame(raw[1]), .checksum_err(cs_err[1]), .timeout_err(to_err[1]));
   dht_reader #(.CLK_FREQ_HZ(1_000_000), .SENSOR_TYPE(0), .START_LOW_US(300), .POLL_MS(3000),
                .TIMEOUT_US(200), .BIT_THRESH_US(40)) u11f (
      .clk(clk), .reset(reset), .start(start[2]), .auto_en(auto_en[2]), .dht_data(l2),
      .busy(busy[2]), .valid(valid[2]), .humidity(hum[2]), .temperature(tmp[2]),
      .raw_frame(raw[2]), .checksum_err(cs_err[2]), .timeout_err(to_err[2]));

   localparam int SLUS [3] = '{1100, 18000, 300};
   typedef struct {int d; logic [39:0] f; logic [15:0] h; logic [15:0] t; bit ok;} vec_t;
   vec_t tbl [6];
   int n_chk = 0, n_fail = 0, cyc = 0;
   int vcnt [3] = '{0, 0, 0};
   logic [15:0] vh [3], vt [3], mh [3], mt [3];

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk)
      for (int k = 0; k < 3; k++)
         if (valid[k]) begin
            vcnt[k]++;
            vh[k] = hum[k];
            vt[k] = tmp[k];
         end

   task automatic chk(input string nm, input longint got, input longint exp, input int tol = 0);
      n_chk++;
      if (got > exp + tol || got < exp - tol) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (tol %0d)", nm, got, exp, tol);
      end
   endtask

   // DHT behaviour from the datasheet rules: returns {checksum_ok, humidity, temperature}
   function automatic logic [32:0] model(input bit d22, input logic [39:0] f);
      int b [5];
      int h, t;
      bit ok;
      for (int k = 0; k < 5; k++) b[k] = int'(f[39 - 8 * k -: 8]);
      if (d22) begin
         h = b[0] * 256 + b[1];
         t = (b[2] % 128) * 256 + b[3];
         if (b[2] >= 128) t = -t;
      end else begin
         h = b[0] * 10 + (b[1] < 9 ? b[1] : 9);
         t = b[2] * 10 + ((b[3] % 128) < 9 ? b[3] % 128 : 9);
         if (b[3] >= 128) t = -t;
      end
      ok = (b[0] + b[1] + b[2] + b[3]) % 256 == b[4];
      return {ok, 16'(h), 16'(t)};
   endfunction

   task automatic wait_lvl(input int d, input logic v, input int lim, output int t);
      t = 0;
      while (lv[d] !== v && t < lim) begin
         @(negedge clk);
         t++;
      end
   endtask

   task automatic wait_idle(input int d, input int lim);
      int t = 0;
      while (busy[d] && t < lim) begin
         @(negedge clk);
         t++;
      end
   endtask

   task automatic sense(input int d, input logic [39:0] f);
      repeat (25) @(negedge clk);
      sl[d] = 1'b1;
      repeat (80) @(negedge clk);
      sl[d] = 1'b0;
      repeat (80) @(negedge clk);
      for (int k = 39; k >= 0; k--) begin
         sl[d] = 1'b1;
         repeat ($urandom_range(30, 15)) @(negedge clk);
         sl[d] = 1'b0;
         repeat (f[k] ? $urandom_range(70, 52) : $urandom_range(28, 10)) @(negedge clk);
      end
      sl[d] = 1'b1;
      repeat (40) @(negedge clk);
      sl[d] = 1'b0;
   endtask

   task automatic run(input int d, input logic [39:0] f, input logic [15:0] eh, input logic [15:0] et,
                      input bit ok, input string nm);
      int t, v0;
      v0 = vcnt[d];
      @(negedge clk) start[d] = 1'b1;
      @(negedge clk) start[d] = 1'b0;
      chk({nm, " line low after start"}, lv[d], 0);
      chk({nm, " busy"}, busy[d], 1);
      wait_lvl(d, 1'b1, SLUS[d] + 20, t);
      chk({nm, " start low us"}, t, SLUS[d], 1);
      sense(d, f);
      wait_idle(d, 50);
      chk({nm, " busy cleared"}, busy[d], 0);
      chk({nm, " valid pulses"}, vcnt[d] - v0, ok);
      if (ok) begin
         chk({nm, " hum at valid"}, vh[d], eh);
         chk({nm, " temp at valid"}, vt[d], et);
      end
      chk({nm, " humidity"}, hum[d], eh);
      chk({nm, " temperature"}, tmp[d], et);
      chk({nm, " raw_frame"}, raw[d], f);
      chk({nm, " checksum_err"}, cs_err[d], !ok);
      chk({nm, " timeout_err"}, to_err[d], 0);
   endtask

   task automatic reset_chk(input int d, input string nm);
      chk({nm, " busy"}, busy[d], 0);
      chk({nm, " valid"}, valid[d], 0);
      chk({nm, " humidity"}, hum[d], 0);
      chk({nm, " temperature"}, tmp[d], 0);
      chk({nm, " raw_frame"}, raw[d], 0);
      chk({nm, " checksum_err"}, cs_err[d], 0);
      chk({nm, " timeout_err"}, to_err[d], 0);
      chk({nm, " line released"}, lv[d], 1);
   endtask

   initial begin
      #98_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t, c1, c2, c3;
      logic [39:0] f;
      logic [32:0] m;
      tbl[0] = '{0, 40'h028C015FEE, 16'd652, 16'd351, 1'b1};
      tbl[1] = '{0, 40'h028C015FEF, 16'd652, 16'd351, 1'b0};
      tbl[2] = '{0, 40'h0190806576, 16'd400, 16'hFF9B, 1'b1};
      tbl[3] = '{0, 40'hFFFF7FFF7C, 16'hFFFF, 16'h7FFF, 1'b1};
      tbl[4] = '{1, 40'h3700190050, 16'd550, 16'd250, 1'b1};
      tbl[5] = '{2, 40'h2D0C058FCD, 16'd459, 16'hFFC5, 1'b1};
      for (int k = 0; k < 3; k++) begin
         mh[k] = '0;
         mt[k] = '0;
      end
      repeat (3) @(negedge clk);
      reset_chk(0, "reset dht22");
      reset_chk(2, "reset dht11");
      reset = 1'b0;
      repeat (5) @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         run(tbl[i].d, tbl[i].f, tbl[i].h, tbl[i].t, tbl[i].ok, $sformatf("vec%0d", i));
         if (tbl[i].ok) begin
            mh[tbl[i].d] = tbl[i].h;
            mt[tbl[i].d] = tbl[i].t;
         end
      end

      for (int r = 0; r < 5; r++) begin
         int d = r < 3 ? 0 : 2;
         f[39:8] = $urandom;
         f[7:0] = f[39:32] + f[31:24] + f[23:16] + f[15:8];
         if ($urandom_range(3, 0) == 0) f[7:0] ^= 8'h01;
         m = model(d == 0, f);
         if (m[32]) begin
            mh[d] = m[31:16];
            mt[d] = m[15:0];
         end
         run(d, f, mh[d], mt[d], m[32], $sformatf("rand%0d", r));
      end

      @(negedge clk) start[0] = 1'b1;
      @(negedge clk) start[0] = 1'b0;
      wait_lvl(0, 1'b1, 1200, t);
      chk("timeout start low us", t, 1100, 1);
      t = 0;
      while (!to_err[0] && t < 400) begin
         @(negedge clk);
         t++;
      end
      chk("timeout delay us", t, 200, 2);
      chk("timeout busy", busy[0], 0);
      chk("timeout checksum_err", cs_err[0], 0);
      chk("timeout humidity held", hum[0], mh[0]);
      chk("timeout temperature held", tmp[0], mt[0]);

      @(negedge clk) begin
         start[0] = 1'b1;
         start[1] = 1'b1;
      end
      @(negedge clk) start = '0;
      wait_lvl(0, 1'b1, 1200, t);
      repeat (25) @(negedge clk);
      sl[0] = 1'b1;
      repeat (80) @(negedge clk);
      sl[0] = 1'b0;
      repeat (80) @(negedge clk);
      for (int k = 0; k < 10; k++) begin
         sl[0] = 1'b1;
         repeat (20) @(negedge clk);
         sl[0] = 1'b0;
         repeat (60) @(negedge clk);
      end
      chk("mid-frame busy", busy[0], 1);
      chk("dht11 line held low", lv[1], 0);
      @(negedge clk) reset = 1'b1;
      @(negedge clk);
      reset_chk(0, "mid-frame reset");
      chk("reset releases dht11 line", lv[1], 1);
      chk("reset dht11 busy", busy[1], 0);
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         mh[k] = '0;
         mt[k] = '0;
      end

      auto_en[0] = 1'b1;
      wait_lvl(0, 1'b0, 6000, t);
      chk("poll first start", lv[0], 0);
      c1 = cyc;
      wait_lvl(0, 1'b1, 1200, t);
      wait_lvl(0, 1'b0, 6000, t);
      c2 = cyc;
      chk("poll period", c2 - c1, 5000, 2);
      repeat (50) @(negedge clk);
      start[0] = 1'b1;
      @(negedge clk) start[0] = 1'b0;
      wait_lvl(0, 1'b1, 1200, t);
      wait_idle(0, 400);
      chk("poll busy cleared", busy[0], 0);
      wait_lvl(0, 1'b0, 6000, t);
      c3 = cyc;
      chk("poll period with dropped start", c3 - c2, 5000, 2);
      auto_en[0] = 1'b0;
      wait_lvl(0, 1'b1, 1200, t);
      wait_idle(0, 400);
      chk("poll timeout_err", to_err[0], 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
